// File: rtl/carfield_pkg.sv
// Shared definitions for the Carfield peripheral APB decoder: decode windows,
// slave indices and the transfer FSM state type.
package carfield_pkg;

   localparam int unsigned NumSlaves = 5;
   localparam logic [31:0] WinSize   = 32'h0000_1000;

   typedef enum logic [2:0] {
      SLV_CAN      = 3'd0,
      SLV_SYSTIMER = 3'd1,
      SLV_ADVTIMER = 3'd2,
      SLV_WATCHDOG = 3'd3,
      SLV_HYPERBUS = 3'd4
   } slave_idx_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } apb_state_e;

   // Entry i is the base of slave_idx_e value i.
   localparam logic [NumSlaves-1:0][31:0] WinBase = {
      32'h2000_9000, 32'h2000_7000, 32'h2000_5000, 32'h2000_4000, 32'h2000_1000
   };

   function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
      return (addr >= base) && (addr < base + WinSize);
   endfunction

endpackage

// File: rtl/carfield_periph_addr_decode.sv
// Combinational address decoder: one-hot slave select plus hit flag.
// The CAN window is left unmapped when CanEnable is 0.
module carfield_periph_addr_decode
   import carfield_pkg::*;
#(
   parameter bit CanEnable = 1'b1
) (
   input  logic [31:0]          addr_i,
   output logic [NumSlaves-1:0] sel_o,
   output logic                 hit_o
);

   always_comb begin
      sel_o = '0;
      for (int unsigned i = 0; i < NumSlaves; i++) begin
         sel_o[i] = in_window(addr_i, WinBase[i]);
      end
      if (!CanEnable) begin
         sel_o[SLV_CAN] = 1'b0;
      end
   end

   assign hit_o = |sel_o;

endmodule

// File: rtl/carfield_periph_apb_decoder.sv
// Request/response to 5-slave APB bridge with address decoding.
// Define CARFIELD_APB_TIMEOUT_EN to abort ACCESS after TimeoutCycles cycles.
module carfield_periph_apb_decoder
   import carfield_pkg::*;
#(
   parameter bit          CanEnable     = 1'b1,
   parameter int unsigned TimeoutCycles = 256
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [31:0]             req_addr_i,
   input  logic                    req_write_i,
   input  logic [31:0]             req_wdata_i,
   input  logic [3:0]              req_strb_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [31:0]             rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic [31:0]             paddr_o,
   output logic [NumSlaves-1:0]    psel_o,
   output logic                    penable_o,
   output logic                    pwrite_o,
   output logic [31:0]             pwdata_o,
   output logic [3:0]              pstrb_o,
   input  logic [NumSlaves*32-1:0] prdata_i,
   input  logic [NumSlaves-1:0]    pready_i,
   input  logic [NumSlaves-1:0]    pslverr_i
);

   if (TimeoutCycles < 2 || TimeoutCycles > 65535) begin : g_bad_timeout
      $error("TimeoutCycles must be within 2..65535");
   end

   apb_state_e           state_q, state_d;
   logic [31:0]          addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]           strb_q, strb_d;
   logic                 write_q, write_d, err_q, err_d, done_q, done_d;
   logic [NumSlaves-1:0] sel_q, sel_d, dec_sel;
   logic                 dec_hit, slv_ready, slv_err, timeout_hit, apb_active;
   logic [31:0]          slv_rdata;

   carfield_periph_addr_decode #(
      .CanEnable(CanEnable)
   ) i_addr_decode (
      .addr_i(req_addr_i),
      .sel_o (dec_sel),
      .hit_o (dec_hit)
   );

   always_comb begin
      slv_rdata = '0;
      for (int unsigned i = 0; i < NumSlaves; i++) begin
         if (sel_q[i]) slv_rdata = slv_rdata | prdata_i[i*32 +: 32];
      end
   end

   assign slv_ready = |(pready_i & sel_q);
   assign slv_err   = |(pslverr_i & sel_q);

`ifdef CARFIELD_APB_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;

   assign timeout_hit = (cnt_q == 16'(TimeoutCycles - 1));
   assign cnt_d = (state_q == ST_ACCESS && !done_q && !slv_ready && !timeout_hit)
                  ? cnt_q + 16'd1 : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // done_q marks the one cycle after completion where the APB bus is
   // released while the captured response waits to be presented in RESP.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      sel_d   = sel_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      done_d  = done_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               addr_d  = req_addr_i;
               write_d = req_write_i;
               wdata_d = req_wdata_i;
               strb_d  = req_strb_i;
               sel_d   = dec_sel;
               rdata_d = '0;
               err_d   = !dec_hit;
               done_d  = 1'b0;
               state_d = dec_hit ? ST_SETUP : ST_RESP;
            end
         end
         ST_SETUP: state_d = ST_ACCESS;
         ST_ACCESS: begin
            if (done_q) begin
               done_d  = 1'b0;
               state_d = ST_RESP;
            end else if (slv_ready) begin
               done_d  = 1'b1;
               rdata_d = write_q ? '0 : slv_rdata;
               err_d   = slv_err;
            end else if (timeout_hit) begin
               done_d  = 1'b1;
               rdata_d = '0;
               err_d   = 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               state_d = ST_IDLE;
               sel_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
         sel_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         sel_q   <= sel_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign apb_active  = (state_q == ST_SETUP) || (state_q == ST_ACCESS && !done_q);
   assign req_ready_o = rst_ni && (state_q == ST_IDLE);
   assign rsp_valid_o = (state_q == ST_RESP);
   assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
   assign rsp_err_o   = rsp_valid_o && err_q;
   assign paddr_o     = apb_active ? addr_q : '0;
   assign psel_o      = apb_active ? sel_q : '0;
   assign penable_o   = (state_q == ST_ACCESS) && !done_q;
   assign pwrite_o    = apb_active && write_q;
   assign pwdata_o    = apb_active ? wdata_q : '0;
   assign pstrb_o     = apb_active ? strb_q : '0;

endmodule
